// File: rtl/spike_out_arbiter.sv
// spike_out_arbiter: two-engine round-robin writer into a downstream FIFO.
// Sequences one timestep (IDLE -> RUN -> FLUSH -> DONE), counts the writes it
// issues, and throttles to a single write when the FIFO has one free slot.

`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 8
`endif

module spike_out_arbiter #(
  parameter int IDX_W = `SYNAPSE_INDEX,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step_start,
  input  logic             req0,
  input  logic             req1,
  input  logic [IDX_W-1:0] idx0,
  input  logic [IDX_W-1:0] idx1,
  input  logic             done0,
  input  logic             done1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             full,
  input  logic             almost_full,
  output logic             w_en,
  output logic [IDX_W-1:0] s_index_o,
  output logic             src_o,
  output logic             step_done,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               w_en_q, w_en_d;
  logic [IDX_W-1:0]   s_index_q, s_index_d;
  logic               src_q, src_d;
  logic               step_done_q, step_done_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               last_q, last_d;
  logic               done_f0_q, done_f0_d;
  logic               done_f1_q, done_f1_d;

  logic               can_wr;
  logic               grant_en;
  logic               any_gnt;

  // With one free slot and a write already in flight, the FIFO could be
  // overrun, so hold off until the in-flight write has been absorbed.
  assign can_wr   = !full && !(almost_full && w_en_q);
  assign grant_en = ((state_q == RUN) || (state_q == FLUSH)) && can_wr;

  // Round-robin grant: a lone requester wins; on a tie the engine that did
  // not win last time is served. Grants are mutually exclusive by design.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (grant_en) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign any_gnt = gnt0 || gnt1;

  // Timestep sequencing and sticky done flags.
  always_comb begin
    state_d   = state_q;
    done_f0_d = done_f0_q;
    done_f1_d = done_f1_q;
    unique case (state_q)
      IDLE: begin
        if (step_start) begin
          state_d   = RUN;
          done_f0_d = 1'b0;
          done_f1_d = 1'b0;
        end
      end
      RUN: begin
        // A done pulse counts in the cycle it arrives, so an engine that
        // signals done alongside its last request still finishes this step.
        done_f0_d = done_f0_q || done0;
        done_f1_d = done_f1_q || done1;
        if (done_f0_d && done_f1_d) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!req0 && !req1 && !w_en_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port register inputs and status outputs derived from the next state.
  always_comb begin
    w_en_d      = any_gnt;
    s_index_d   = s_index_q;
    src_d       = src_q;
    last_d      = last_q;
    wr_cnt_d    = wr_cnt_q;
    if (any_gnt) begin
      s_index_d = gnt1 ? idx1 : idx0;
      src_d     = gnt1;
      last_d    = gnt1;
    end
    if ((state_q == IDLE) && step_start) begin
      wr_cnt_d = '0;
    end else if (any_gnt && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    step_done_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // All state; reset drops the block straight back to IDLE at any point.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      w_en_q      <= 1'b0;
      s_index_q   <= '0;
      src_q       <= 1'b0;
      step_done_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_cnt_q    <= '0;
      last_q      <= 1'b1;
      done_f0_q   <= 1'b0;
      done_f1_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order inside the block.
      state_q     <= state_d;
      w_en_q      <= w_en_d;
      s_index_q   <= s_index_d;
      src_q       <= src_d;
      step_done_q <= step_done_d;
      busy_q      <= busy_d;
      wr_cnt_q    <= wr_cnt_d;
      last_q      <= last_d;
      done_f0_q   <= done_f0_d;
      done_f1_q   <= done_f1_d;
    end
  end

  assign w_en      = w_en_q;
  assign s_index_o = s_index_q;
  assign src_o     = src_q;
  assign step_done = step_done_q;
  assign wr_cnt    = wr_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spike_out_arbiter.sv
// Directed bench for spike_out_arbiter: grants are checked in the cycle they
// occur, expected writes are queued and matched when w_en appears.

module tb_spike_out_arbiter;

  localparam int IW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          step_start, req0, req1, done0, done1, full, almost_full;
  logic [IW-1:0] idx0, idx1;
  logic          gnt0, gnt1, w_en, src_o, step_done, busy;
  logic [IW-1:0] s_index_o;
  logic [CW-1:0] wr_cnt;

  logic          s_gnt0, s_gnt1, s_w_en, s_src_o, s_step_done, s_busy;
  logic [IW-1:0] s_s_index_o;
  logic [3:0]    s_wr_cnt;

  typedef struct {
    logic          src;
    logic [IW-1:0] idx;
  } wr_t;

  wr_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  spike_out_arbiter #(.IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .step_start(step_start),
    .req0(req0), .req1(req1), .idx0(idx0), .idx1(idx1),
    .done0(done0), .done1(done1), .gnt0(gnt0), .gnt1(gnt1),
    .full(full), .almost_full(almost_full), .w_en(w_en),
    .s_index_o(s_index_o), .src_o(src_o), .step_done(step_done),
    .wr_cnt(wr_cnt), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  spike_out_arbiter #(.IDX_W(IW), .CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .step_start(step_start),
    .req0(req0), .req1(req1), .idx0(idx0), .idx1(idx1),
    .done0(done0), .done1(done1), .gnt0(s_gnt0), .gnt1(s_gnt1),
    .full(full), .almost_full(almost_full), .w_en(s_w_en),
    .s_index_o(s_s_index_o), .src_o(s_src_o), .step_done(s_step_done),
    .wr_cnt(s_wr_cnt), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic src, input logic [IW-1:0] idx);
    wr_t w;
    w.src = src;
    w.idx = idx;
    sb.push_back(w);
  endtask

  // Close the current timestep with both engines done and no requests.
  task automatic end_step(input string tag);
    int n;
    cyc(); done0 = 1'b1; done1 = 1'b1; #1;
    cyc(); done0 = 1'b0; done1 = 1'b0; #1;
    check({tag, "_flush_busy"}, busy, 1);
    n = 0;
    while (!step_done && n < 8) begin
      cyc(); #1;
      n++;
    end
    check({tag, "_step_done"}, step_done, 1);
    cyc(); #1;
    check({tag, "_step_done_pulse"}, step_done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  // Scoreboard: every observed write must match the oldest expected one.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rstn && w_en) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected_write: observed src %0d idx %0h expected none", src_o, s_index_o);
        end
        if (sb.size() != 0) begin
          w = sb.pop_front();
          check("sb_src", src_o, w.src);
          check("sb_idx", s_index_o, w.idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; step_start = 1'b0; req0 = 1'b1; req1 = 1'b1;
    idx0 = '0; idx1 = '0; done0 = 1'b0; done1 = 1'b0;
    full = 1'b0; almost_full = 1'b0;

    // Reset values, with requests asserted
    cyc(); cyc(); #1;
    check("rst_w_en", w_en, 0);
    check("rst_s_index", s_index_o, 0);
    check("rst_src", src_o, 0);
    check("rst_step_done", step_done, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    cyc(); rstn = 1'b1; req0 = 1'b0; req1 = 1'b0;

    // Nothing moves without step_start
    repeat (3) begin
      cyc(); #1;
      check("post_rst_idle", busy, 0);
    end

    // Fairness: both engines request for six cycles
    cyc(); step_start = 1'b1; #1;
    cyc(); step_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin cyc(); end
      req0 = 1'b1; req1 = 1'b1;
      idx0 = 8'h10 + 8'(k); idx1 = 8'h20 + 8'(k);
      #1;
      check("fair_gnt0", gnt0, (k % 2 == 0));
      check("fair_gnt1", gnt1, (k % 2 == 1));
      if (k != 0) check("fair_w_en", w_en, 1);
      if (k % 2 == 0) expect_write(1'b0, 8'h10 + 8'(k));
      else            expect_write(1'b1, 8'h20 + 8'(k));
    end
    cyc(); req0 = 1'b0; req1 = 1'b0; #1;
    check("fair_w_en_last", w_en, 1);
    check("fair_wr_cnt", wr_cnt, 6);
    cyc(); #1;
    check("fair_w_en_off", w_en, 0);
    end_step("fair");

    // Idle hold: request waits in IDLE, served right after step_start
    cyc(); req0 = 1'b1; idx0 = 8'h2A;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("idle_gnt0", gnt0, 0);
      cyc();
    end
    step_start = 1'b1; #1;
    check("idle_start_gnt0", gnt0, 0);
    cyc(); step_start = 1'b0; #1;
    check("idle_first_gnt0", gnt0, 1);
    expect_write(1'b0, 8'h2A);
    cyc(); req0 = 1'b0; #1;
    check("idle_s_index", s_index_o, 8'h2A);
    check("idle_w_en", w_en, 1);
    end_step("idle");

    // Backpressure: one free slot halves the write rate, full stops it
    cyc(); step_start = 1'b1; #1;
    cyc(); step_start = 1'b0; almost_full = 1'b1; req0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin cyc(); end
      idx0 = 8'h40 + 8'(k);
      #1;
      check("bp_gnt0", gnt0, (k % 2 == 0));
      check("bp_w_en", w_en, (k % 2 == 1));
      if (k % 2 == 0) expect_write(1'b0, 8'h40 + 8'(k));
    end
    cyc(); full = 1'b1; #1;
    check("full_gnt0", gnt0, 0);
    cyc(); #1;
    check("full_gnt0_hold", gnt0, 0);
    check("full_w_en", w_en, 0);
    cyc(); full = 1'b0; almost_full = 1'b0; idx0 = 8'h55; #1;
    check("unfull_gnt0", gnt0, 1);
    expect_write(1'b0, 8'h55);
    cyc(); req0 = 1'b0; #1;
    check("unfull_w_en", w_en, 1);
    end_step("bp");

    // Completion: done0 at cycle 3, done1 with req1 at cycle 7
    cyc(); step_start = 1'b1; #1;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      step_start = 1'b0;
      done0 = (c == 3);
      done1 = (c == 7);
      req1  = (c == 7);
      idx1  = 8'h77;
      #1;
      if (c == 6) begin
        // A stray step_start in RUN must not restart the count
        check("cmp_busy_mid", busy, 1);
      end
      if (c == 7) begin
        check("cmp_gnt1", gnt1, 1);
        check("cmp_step_done_early", step_done, 0);
        expect_write(1'b1, 8'h77);
      end
      if (c == 8) begin
        check("cmp_flush_busy", busy, 1);
        check("cmp_flush_w_en", w_en, 1);
      end
      if (c == 9)  check("cmp_step_done_9", step_done, 0);
      if (c == 10) check("cmp_step_done_10", step_done, 1);
      if (c == 11) begin
        check("cmp_step_done_11", step_done, 0);
        check("cmp_idle_busy", busy, 0);
      end
      if (c == 4) step_start = 1'b1;
    end
    step_start = 1'b0;

    // Saturation: 20 grants against a 16-bit and a 4-bit counter
    cyc(); step_start = 1'b1; #1;
    cyc(); step_start = 1'b0; req0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) begin cyc(); end
      idx0 = 8'(k);
      #1;
      check("sat_gnt0", gnt0, 1);
      expect_write(1'b0, 8'(k));
      if (k == 10) begin
        check("sat_mid_cnt", wr_cnt, 10);
        check("sat_mid_cnt4", s_wr_cnt, 10);
      end
    end
    cyc(); req0 = 1'b0; #1;
    check("sat_cnt16", wr_cnt, 20);
    check("sat_cnt4", s_wr_cnt, 15);
    end_step("sat");

    // Reset in the middle of a write burst
    cyc(); step_start = 1'b1; #1;
    cyc(); step_start = 1'b0; req0 = 1'b1; req1 = 1'b1; idx0 = 8'h61; idx1 = 8'h62; #1;
    expect_write(gnt1, gnt1 ? 8'h62 : 8'h61);
    cyc(); #1;
    check("mid_w_en", w_en, 1);
    rstn = 1'b0; #1;
    sb.delete();
    check("mid_rst_w_en", w_en, 0);
    check("mid_rst_s_index", s_index_o, 0);
    check("mid_rst_src", src_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_cnt", wr_cnt, 0);
    check("mid_rst_step_done", step_done, 0);
    check("mid_rst_gnt0", gnt0, 0);
    check("mid_rst_gnt1", gnt1, 0);
    cyc(); rstn = 1'b1;
    cyc(); #1;
    check("mid_post_idle_gnt0", gnt0, 0);
    step_start = 1'b1;
    cyc(); step_start = 1'b0; #1;
    check("mid_restart_cnt", wr_cnt, 0);
    check("mid_restart_busy", busy, 1);
    check("mid_restart_gnt0", gnt0, 1);
    expect_write(1'b0, 8'h61);
    cyc(); req0 = 1'b0; req1 = 1'b0; #1;
    check("mid_restart_cnt1", wr_cnt, 1);
    end_step("mid");

    cyc(); #1;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_out_arbiter.md
SPIKE_OUT_ARBITER -- requirements
Module: spike_out_arbiter

Interface
REQ-001 Parameter IDX_W, default `SYNAPSE_INDEX, width of every spike index path.
REQ-002 Parameter CNT_W, default 16, width of the per-timestep write counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 step_start  input  1  one-cycle pulse; opens a timestep.
REQ-006 req0 / req1  input  1  engine 0 / 1 holds a spike index for writing.
REQ-007 idx0 / idx1  input  IDX_W  engine 0 / 1 spike index; stable while the matching req is high.
REQ-008 done0 / done1  input  1  one-cycle pulse; engine 0 / 1 has finished its convolution for this timestep.
REQ-009 gnt0 / gnt1  output  1  combinational accept; the index is consumed in this cycle.
REQ-010 full / almost_full  input  1  status from the next FIFO.
REQ-011 w_en  output  1  registered write strobe to the next FIFO.
REQ-012 s_index_o  output  IDX_W  registered write data.
REQ-013 src_o  output  1  registered engine id of the current write.
REQ-014 step_done  output  1  registered one-cycle pulse; timestep complete.
REQ-015 wr_cnt  output  CNT_W  writes issued in the current timestep.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 State machine states: IDLE, RUN, FLUSH, DONE.
REQ-018 IDLE -> RUN when step_start=1; step_start in any other state is ignored.
REQ-019 RUN -> FLUSH when both sticky done flags are set.
REQ-020 FLUSH -> DONE when req0=0, req1=0 and no write is pending.
REQ-021 DONE -> IDLE after exactly one cycle; step_done=1 only in DONE.
REQ-022 Sticky flags: done_f0/done_f1 set by done0/done1 in RUN and cleared on entry to RUN.
REQ-023 A done pulse in the same cycle as req from the same engine sets the flag; the request is still served.
REQ-024 can_wr = !full && !(almost_full && w_en); this limits writes to one while the FIFO has one free slot.
REQ-025 Grants are allowed only in RUN or FLUSH and only when can_wr=1; gnt0 and gnt1 are never both high.
REQ-026 Round-robin arbitration with a 1-bit last pointer:
  - one requester: that requester is granted;
  - both requesting: the engine not equal to last is granted;
  - last is updated to the granted id.
REQ-027 Register update on a grant: w_en=1, s_index_o=idx of the granted engine, src_o=granted id. With no grant, w_en=0 and s_index_o/src_o hold their values.
REQ-028 Latency: gnt in cycle t -> w_en in cycle t+1; sustained throughput 1 write/cycle.
REQ-029 wr_cnt is cleared to 0 on entry to RUN, increments by 1 per grant and saturates at 2^CNT_W-1.
REQ-030 In IDLE and DONE, requests stay pending (gnt=0); no data is dropped.

Reset
REQ-031 On rstn=0 the block asynchronously returns to IDLE, including mid-timestep.
REQ-032 Reset values: w_en=0, s_index_o=0, src_o=0, step_done=0, wr_cnt=0, busy=0, last=1 (engine 0 wins first), done_f0=done_f1=0.
REQ-033 gnt0 and gnt1 are 0 while rstn=0.
REQ-034 The first state transition after reset release requires a step_start pulse.

Verification
REQ-035 Fairness:
  - stimulus: step_start, then req0=req1=1 held for 6 cycles, FIFO empty;
  - response: grants E0,E1,E0,E1,E0,E1; w_en high for 6 consecutive cycles starting 1 cycle after the first grant; wr_cnt=6.
REQ-036 Backpressure:
  - stimulus: almost_full=1 and full=0 with continuous req0;
  - response: writes alternate w_en=1,0,1,0; when full=1, gnt0=0 and w_en=0 from the next cycle.
REQ-037 Completion:
  - stimulus: done0 at cycle 3, done1 together with req1 at cycle 7;
  - response: req1 is granted, FLUSH is entered, step_done pulses for one cycle two cycles later, then IDLE.
REQ-038 Idle hold:
  - stimulus: req0=1 with idx0=0x2A in IDLE for 5 cycles, then step_start;
  - response: gnt0=0 during IDLE; first grant in the cycle after step_start; s_index_o=0x2A.
REQ-039 Reset mid-operation:
  - stimulus: rstn=0 during RUN with w_en=1;
  - response: all outputs take REQ-032 values immediately; step_start after release starts normally with wr_cnt=0.
REQ-040 Saturation:
  - stimulus: CNT_W=4 with 20 grants;
  - response: wr_cnt stops at 15 and does not wrap.
